// File: rtl/onchip_memory_arbiter_pkg.sv
// Shared definitions for the two-requester on-chip memory arbiter.
// Optional feature macro: ONCHIP_ARB_LOCK_EN (adds m0_lock/m1_lock ports).
package onchip_memory_arbiter_pkg;

    // Default shared-RAM geometry: 4K words of 32 bits.
    localparam int ARB_ADDR_W = 12;
    localparam int ARB_DATA_W = 32;

    // Requester identifier: 0 or 1.
    typedef logic req_id_t;

    // Convert a one-hot grant into the requester id (grant[1] set means 1).
    function automatic req_id_t onehot_to_id(input logic [1:0] oh);
        return oh[1];
    endfunction

endpackage

// File: rtl/onchip_rr_grant.sv
// Two-way round-robin grant with an optional lock mask.
// A non-zero one-hot lock restricts the grant to that requester only.
module onchip_rr_grant
    import onchip_memory_arbiter_pkg::*;
(
    input  logic [1:0] i_req,
    input  req_id_t    i_last_grant,
    input  logic [1:0] i_lock,
    output logic [1:0] o_grant
);

    // Pick at most one requester; on a tie the one not granted last wins.
    always_comb begin
        o_grant = 2'b00;
        if (i_lock != 2'b00) begin
            o_grant = i_req & i_lock;
        end else if (i_req == 2'b11) begin
            o_grant = (i_last_grant == 1'b1) ? 2'b01 : 2'b10;
        end else begin
            o_grant = i_req;
        end
    end

endmodule

// File: rtl/onchip_memory_arbiter.sv
// Arbitrates two Avalon-style requesters onto one single-port on-chip RAM
// with 1-cycle read latency. Optional feature macro: ONCHIP_ARB_LOCK_EN.
// Handshake: a request (read|write) is accepted in the cycle its
// waitrequest is 0; reads return exactly one cycle later qualified by
// readdatavalid; writes have no response.
module onchip_memory_arbiter
    import onchip_memory_arbiter_pkg::*;
#(
    parameter  int ADDR_W = ARB_ADDR_W,
    parameter  int DATA_W = ARB_DATA_W,
    localparam int BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset_n,
`ifdef ONCHIP_ARB_LOCK_EN
    input  logic              m0_lock,
    input  logic              m1_lock,
`endif
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata
);

    req_id_t    r_last_grant;
    logic       r_rd_valid;
    req_id_t    r_rd_owner;

    logic [1:0] w_req;
    logic [1:0] w_lock;
    logic [1:0] w_grant;
    logic       w_accept;
    req_id_t    w_gid;
    logic       w_sel_write;

    // Nothing is requested (so nothing is granted) while reset is held.
    assign w_req = {m1_read | m1_write, m0_read | m0_write} & {2{reset_n}};

`ifdef ONCHIP_ARB_LOCK_EN
    logic    r_lock_valid;
    req_id_t r_lock_owner;
    logic    w_sel_lock;

    assign w_lock     = r_lock_valid ? (r_lock_owner ? 2'b10 : 2'b01) : 2'b00;
    assign w_sel_lock = w_gid ? m1_lock : m0_lock;

    // Every accepted request rewrites the lock; only the owner can be accepted while locked.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_lock_valid <= 1'b0;
            r_lock_owner <= 1'b0;
        end else if (w_accept) begin
            r_lock_valid <= w_sel_lock;
            r_lock_owner <= w_gid;
        end
    end
`else
    assign w_lock = 2'b00;
`endif

    onchip_rr_grant u_grant (
        .i_req        (w_req),
        .i_last_grant (r_last_grant),
        .i_lock       (w_lock),
        .o_grant      (w_grant)
    );

    assign w_accept    = |w_grant;
    assign w_gid       = onehot_to_id(w_grant);
    // Read and write both high counts as a write.
    assign w_sel_write = w_gid ? m1_write : m0_write;

    assign m0_waitrequest = ~w_grant[0];
    assign m1_waitrequest = ~w_grant[1];

    assign mem_address    = w_gid ? m1_address    : m0_address;
    assign mem_byteenable = w_gid ? m1_byteenable : m0_byteenable;
    assign mem_writedata  = w_gid ? m1_writedata  : m0_writedata;
    assign mem_chipselect = w_accept;
    assign mem_write      = w_accept & w_sel_write;
    assign mem_clken      = reset_n;

    // Read data is broadcast; readdatavalid alone tells the owner it is theirs.
    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;
    assign m0_readdatavalid = reset_n & r_rd_valid & (r_rd_owner == 1'b0);
    assign m1_readdatavalid = reset_n & r_rd_valid & (r_rd_owner == 1'b1);

    // Remember the last winner and the single read in flight.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_last_grant <= 1'b1;
            r_rd_valid   <= 1'b0;
            r_rd_owner   <= 1'b0;
        end else begin
            r_rd_valid <= w_accept & ~w_sel_write;
            if (w_accept) begin
                r_last_grant <= w_gid;
                r_rd_owner   <= w_gid;
            end
        end
    end

endmodule

// File: tb/tb_onchip_memory_arbiter.sv
// Self-checking bench for onchip_memory_arbiter: directed scenarios followed
// by randomized traffic, checked against a behavioural arbitration/RAM model.
module tb_onchip_memory_arbiter;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [AW-1:0] m0_address, m1_address;
  logic [BW-1:0] m0_byteenable, m1_byteenable;
  logic          m0_read, m0_write, m1_read, m1_write;
  logic [DW-1:0] m0_writedata, m1_writedata;
  logic          m0_lock, m1_lock;
  logic          m0_waitrequest, m1_waitrequest;
  logic [DW-1:0] m0_readdata, m1_readdata;
  logic          m0_readdatavalid, m1_readdatavalid;
  logic [AW-1:0] mem_address;
  logic [BW-1:0] mem_byteenable;
  logic          mem_chipselect, mem_write, mem_clken;
  logic [DW-1:0] mem_writedata, mem_readdata;

  onchip_memory_arbiter dut (
    .clk              (clk),
    .reset_n          (reset_n),
`ifdef ONCHIP_ARB_LOCK_EN
    .m0_lock          (m0_lock),
    .m1_lock          (m1_lock),
`endif
    .m0_address       (m0_address),
    .m0_byteenable    (m0_byteenable),
    .m0_read          (m0_read),
    .m0_write         (m0_write),
    .m0_writedata     (m0_writedata),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m1_address       (m1_address),
    .m1_byteenable    (m1_byteenable),
    .m1_read          (m1_read),
    .m1_write         (m1_write),
    .m1_writedata     (m1_writedata),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
    .mem_address      (mem_address),
    .mem_byteenable   (mem_byteenable),
    .mem_chipselect   (mem_chipselect),
    .mem_write        (mem_write),
    .mem_writedata    (mem_writedata),
    .mem_clken        (mem_clken),
    .mem_readdata     (mem_readdata)
  );

  // ---------------- RAM behind the arbiter (1-cycle read latency) ----------------
  bit [DW-1:0] ram [1 << AW];
  logic [DW-1:0] ram_q = '0;
  assign mem_readdata = ram_q;

  always @(posedge clk) begin
    if (mem_chipselect && mem_clken) begin
      if (mem_write) begin
        for (int b = 0; b < BW; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        ram_q <= ram[mem_address];
      end
    end
  end

  // ---------------- reference model state ----------------
  bit [DW-1:0]   ref_mem [1 << AW];
  logic [DW-1:0] exp_q[$];
  int            last_g;
  bit            pend;
  int            pend_owner;
  bit            lk_valid;
  int            lk_owner;

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic model_reset();
    last_g   = 1;
    pend     = 0;
    lk_valid = 0;
    lk_owner = 0;
    exp_q.delete();
  endtask

  // Hold reset for n cycles with the current inputs, checking reset outputs.
  task automatic do_reset(input int n);
    reset_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      #1;
      chk("rst_wait0", m0_waitrequest, 1);
      chk("rst_wait1", m1_waitrequest, 1);
      chk("rst_rdv0", m0_readdatavalid, 0);
      chk("rst_rdv1", m1_readdatavalid, 0);
      chk("rst_cs", mem_chipselect, 0);
      chk("rst_wr", mem_write, 0);
      chk("rst_clken", mem_clken, 0);
      @(posedge clk);
      #1;
    end
    reset_n = 1'b1;
    model_reset();
  endtask

  // One clock cycle: drive both requesters, check against the model, advance the model.
  task automatic step(input logic r0, input logic w0, input logic [AW-1:0] a0,
                      input logic [DW-1:0] d0, input logic [BW-1:0] be0, input logic lk0,
                      input logic r1, input logic w1, input logic [AW-1:0] a1,
                      input logic [DW-1:0] d1, input logic [BW-1:0] be1, input logic lk1);
    bit q0, q1, gw, glk;
    int g;
    logic [AW-1:0] ga;
    logic [DW-1:0] gd, e;
    logic [BW-1:0] gbe;
    m0_read = r0; m0_write = w0; m0_address = a0; m0_writedata = d0; m0_byteenable = be0; m0_lock = lk0;
    m1_read = r1; m1_write = w1; m1_address = a1; m1_writedata = d1; m1_byteenable = be1; m1_lock = lk1;
    #1;
    q0 = r0 | w0;
    q1 = r1 | w1;
    g = -1;
    if (lk_valid) begin
      if (lk_owner == 0 && q0) g = 0;
      else if (lk_owner == 1 && q1) g = 1;
    end else if (q0 && q1) g = (last_g == 0) ? 1 : 0;
    else if (q0) g = 0;
    else if (q1) g = 1;
    gw  = (g == 1) ? w1 : w0;
    ga  = (g == 1) ? a1 : a0;
    gd  = (g == 1) ? d1 : d0;
    gbe = (g == 1) ? be1 : be0;
    glk = (g == 1) ? lk1 : lk0;

    chk("wait0", m0_waitrequest, (g != 0));
    chk("wait1", m1_waitrequest, (g != 1));
    chk("chipselect", mem_chipselect, (g >= 0));
    chk("mem_write", mem_write, (g >= 0) && gw);
    chk("clken", mem_clken, 1);
    if (g >= 0) chk("mem_address", mem_address, ga);
    if (g >= 0 && gw) begin
      chk("mem_wdata", mem_writedata, gd);
      chk("mem_be", mem_byteenable, gbe);
    end
    chk("rdv0", m0_readdatavalid, pend && pend_owner == 0);
    chk("rdv1", m1_readdatavalid, pend && pend_owner == 1);
    if (pend) begin
      e = exp_q.pop_front();
      chk("rdata0", m0_readdata, e);
      chk("rdata1", m1_readdata, e);
    end

    pend = 0;
    if (g >= 0) begin
      last_g = g;
      if (gw) begin
        for (int b = 0; b < BW; b++)
          if (gbe[b]) ref_mem[ga][8*b +: 8] = gd[8*b +: 8];
      end else begin
        pend = 1;
        pend_owner = g;
        exp_q.push_back(ref_mem[ga]);
      end
`ifdef ONCHIP_ARB_LOCK_EN
      lk_valid = glk;
      lk_owner = g;
`endif
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, '0, '0, '0, 0, 0, 0, '0, '0, '0, 0);
  endtask

  task automatic rd(input int who, input logic [AW-1:0] a);
    if (who == 0) step(1, 0, a, '0, '1, 0, 0, 0, '0, '0, '0, 0);
    else          step(0, 0, '0, '0, '0, 0, 1, 0, a, '0, '1, 0);
  endtask

  task automatic wr(input int who, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
    if (who == 0) step(0, 1, a, d, be, 0, 0, 0, '0, '0, '0, 0);
    else          step(0, 0, '0, '0, '0, 0, 0, 1, a, d, be, 0);
  endtask

  // Drive both requesters idle and look at the returning read data directly.
  task automatic peek_rdata(input string tag, input int who, input logic [DW-1:0] exp);
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
    #1;
    if (who == 0) chk({tag, "_rdv"}, m0_readdatavalid, 1);
    else          chk({tag, "_rdv"}, m1_readdatavalid, 1);
    chk(tag, m0_readdata, exp);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    m0_read = 0; m0_write = 0; m0_address = '0; m0_writedata = '0; m0_byteenable = '0; m0_lock = 0;
    m1_read = 0; m1_write = 0; m1_address = '0; m1_writedata = '0; m1_byteenable = '0; m1_lock = 0;
    reset_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset(3);

    // Write then read-after-write on m0.
    wr(0, 12'h010, 32'hDEADBEEF, 4'hF);
    rd(0, 12'h010);
    peek_rdata("raw_deadbeef", 0, 32'hDEADBEEF);
    idle();

    // Byte-enable merge.
    wr(0, 12'h020, 32'hFFFFFFFF, 4'hF);
    wr(0, 12'h020, 32'h0000AB00, 4'h2);
    rd(0, 12'h020);
    peek_rdata("be_merge", 0, 32'hFFFFABFF);
    idle();

    // Both read continuously from reset: grants alternate starting with m0.
    do_reset(1);
    for (int i = 0; i < 8; i++)
      step(1, 0, 12'(i), '0, '1, 0, 1, 0, 12'(16 + i), '0, '1, 0);
    idle();

    // Single requester at the top address.
    rd(1, 12'hFFF);
    idle();

    // Read accepted, reset in the following cycle: the return is dropped.
    rd(0, 12'h010);
    m0_read = 1;
    do_reset(1);
    idle();
    idle();

`ifdef ONCHIP_ARB_LOCK_EN
    // m1 locks, m0 stalls while m1 is idle, lock released by m1's unlocked write.
    step(0, 0, '0, '0, '0, 0, 0, 1, 12'h030, 32'h12345678, 4'hF, 1);
    for (int i = 0; i < 4; i++) step(1, 0, 12'h030, '0, '1, 0, 0, 0, '0, '0, '0, 0);
    step(1, 0, 12'h030, '0, '1, 0, 0, 1, 12'h031, 32'hCAFEF00D, 4'hF, 0);
    step(1, 0, 12'h030, '0, '1, 0, 0, 0, '0, '0, '0, 0);
    idle();
`endif

    // Randomized traffic over a small address window plus the top word.
    for (int i = 0; i < 600; i++) begin
      logic r0, w0, r1, w1;
      logic [AW-1:0] a0, a1;
      r0 = ($urandom_range(0, 99) < 45);
      w0 = ($urandom_range(0, 99) < 30);
      r1 = ($urandom_range(0, 99) < 45);
      w1 = ($urandom_range(0, 99) < 30);
      a0 = ($urandom_range(0, 9) == 0) ? 12'hFFF : 12'($urandom_range(0, 15));
      a1 = ($urandom_range(0, 9) == 0) ? 12'hFFF : 12'($urandom_range(0, 15));
      step(r0, w0, a0, DW'($urandom), BW'($urandom_range(0, 15)), 0,
           r1, w1, a1, DW'($urandom), BW'($urandom_range(0, 15)), 0);
      if ($urandom_range(0, 199) == 0) do_reset(1);
    end
    idle();
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/onchip_memory_arbiter.md
ONCHIP_MEMORY_ARBITER -- requirements
Module: onchip_memory_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, word address width of shared RAM.
REQ-002 SHALL have parameter DATA_W, default 32, data width; BE_W = DATA_W/8 (default 4).
REQ-003 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset_n  in  1  synchronous, active-low reset.
REQ-005 SHALL have per requester i in {0,1}: m<i>_address in ADDR_W, m<i>_byteenable in BE_W, m<i>_read in 1, m<i>_write in 1, m<i>_writedata in DATA_W.
REQ-006 SHALL have per requester: m<i>_waitrequest out 1 (request not accepted this cycle), m<i>_readdata out DATA_W, m<i>_readdatavalid out 1.
REQ-007 SHALL have memory side: mem_address out ADDR_W, mem_byteenable out BE_W, mem_chipselect out 1, mem_write out 1, mem_writedata out DATA_W, mem_clken out 1, mem_readdata in DATA_W.
REQ-008 SHALL have, only when ONCHIP_ARB_LOCK_EN is defined, m0_lock in 1 and m1_lock in 1.

Function
REQ-009 SHALL treat requester i as requesting when m<i>_read | m<i>_write; read and write both high is write.
REQ-010 SHALL accept at most one request per cycle; accepted requester sees m<i>_waitrequest=0 combinationally in that cycle, others see 1.
REQ-011 SHALL arbitrate round-robin: with both requesting, grant requester != last_grant; single requester granted immediately.
REQ-012 SHALL update last_grant register only on an accepted request.
REQ-013 SHALL drive mem_* from the granted requester combinationally; mem_chipselect=1 only when a request is accepted; mem_write=1 only for accepted write.
REQ-014 SHALL drive mem_clken constantly 1 after reset.
REQ-015 SHALL track one read in flight (rd_valid, rd_owner registers); RAM read latency is 1 cycle.
REQ-016 SHALL assert m<owner>_readdatavalid exactly one cycle after acceptance of a read, with m<owner>_readdata = mem_readdata that cycle.
REQ-017 SHALL drive m<i>_readdata = mem_readdata to both requesters; only readdatavalid qualifies.
REQ-018 SHALL allow back-to-back accepted reads (one per cycle), interleaved between requesters, each returning in order.
REQ-019 SHALL issue writes with zero response; write followed next cycle by read of same address returns new data.
REQ-020 SHALL hold waitrequest=1 for all requesters while reset_n=0.

Reset
REQ-021 SHALL on reset_n=0 at clk edge: last_grant=1 (so requester 0 wins first tie), rd_valid=0, lock_owner cleared.
REQ-022 SHALL reset outputs: all waitrequest=1, readdatavalid=0, mem_chipselect=0, mem_write=0, mem_clken=0.
REQ-023 SHALL drop an in-flight read on reset mid-operation; no readdatavalid after reset release.

Configuration
REQ-024 SHALL with ONCHIP_ARB_LOCK_EN defined: accepted request with m<i>_lock=1 sets lock_owner=i; while locked only owner granted; lock releases on owner's first accepted request with lock=0.
REQ-025 SHALL with ONCHIP_ARB_LOCK_EN defined: locked owner idle keeps lock (other requester stalls).
REQ-026 SHALL without ONCHIP_ARB_LOCK_EN: no lock ports, no lock state, pure round-robin.

Structure
REQ-027 SHALL place ADDR_W/DATA_W defaults and requester-id typedef (1-bit) in package onchip_memory_arbiter_pkg.
REQ-028 SHALL implement grant logic in sub-module onchip_rr_grant (2-way round-robin, inputs req[1:0], last_grant, lock; output grant one-hot).

Verification
REQ-029 SHALL cover: m0 write addr 0x010 data 0xDEADBEEF be 0xF, next cycle m0 read 0x010 -> m0_readdatavalid one cycle later, readdata 0xDEADBEEF.
REQ-030 SHALL cover: m0,m1 both read continuously from reset -> grants alternate 0,1,0,1; each readdatavalid to correct owner 1 cycle after acceptance.
REQ-031 SHALL cover: write 0xFFFFFFFF to 0x020, then be=0x2 data 0x0000AB00 -> read 0x020 returns 0xFFFFABFF.
REQ-032 SHALL cover: read accepted then reset_n=0 next cycle -> no readdatavalid; outputs at reset values.
REQ-033 SHALL cover (LOCK_EN): m1 writes with lock=1, m0 requesting 4 cycles -> m0 waitrequest=1 until m1 request with lock=0 accepted.
REQ-034 SHALL cover: only m1 requests address 0xFFF (wrap boundary) -> accepted with zero wait, mem_address=0xFFF.
